mips_multi_control: RTL and testbench

MIPS_MULTI_CONTROL -- requirements
Module: mips_multi_control

---
 rtl/mips_ctrl_pkg.sv | 55 +++++
 rtl/mips_multi_control_alu_decoder.sv | 33 +++
 rtl/mips_multi_control.sv | 170 +++++++++++++++++
 tb/tb_mips_multi_control.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_pkg
//  Purpose  : Shared encodings for the multicycle MIPS controller: FSM state
//             codes, opcode and funct values, ALUControl codes and ALUSrcB
//             select codes.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  // State codes are visible on state_o, so the numeric values are fixed.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTEXEC   = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10
  } state_t;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;

  // R-type funct codes (instruction bits [5:0])
  localparam logic [5:0] C_FUNCT_ADD = 6'b100000;
  localparam logic [5:0] C_FUNCT_SUB = 6'b100010;
  localparam logic [5:0] C_FUNCT_AND = 6'b100100;
  localparam logic [5:0] C_FUNCT_OR  = 6'b100101;
  localparam logic [5:0] C_FUNCT_SLT = 6'b101010;

  // ALUControl codes
  localparam logic [2:0] C_ALU_ADD = 3'b010;
  localparam logic [2:0] C_ALU_SUB = 3'b110;
  localparam logic [2:0] C_ALU_AND = 3'b000;
  localparam logic [2:0] C_ALU_OR  = 3'b001;
  localparam logic [2:0] C_ALU_SLT = 3'b111;

  // ALUSrcB selects
  localparam logic [1:0] C_SRCB_REG     = 2'b00;
  localparam logic [1:0] C_SRCB_FOUR    = 2'b01;
  localparam logic [1:0] C_SRCB_IMM     = 2'b10;
  localparam logic [1:0] C_SRCB_IMM_SH2 = 2'b11;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mips_multi_control_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Purpose  : Maps an R-type funct field to an ALUControl code and flags
//             whether the funct is one the datapath implements.
//  Ports    : i_funct       [5:0] instruction funct field
//             o_alu_control [2:0] ALU operation code (add for unknown funct)
//             o_supported         1 when i_funct is a recognised operation
//  Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_supported
);

  always_comb begin
    o_alu_control = C_ALU_ADD;
    o_supported   = 1'b1;
    case (i_funct)
      C_FUNCT_ADD: o_alu_control = C_ALU_ADD;
      C_FUNCT_SUB: o_alu_control = C_ALU_SUB;
      C_FUNCT_AND: o_alu_control = C_ALU_AND;
      C_FUNCT_OR:  o_alu_control = C_ALU_OR;
      C_FUNCT_SLT: o_alu_control = C_ALU_SLT;
      default:     o_supported   = 1'b0;
    endcase
  end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/mips_multi_control.sv
`default_nettype none
// ============================================================================
//  Module   : mips_multi_control
//  Purpose  : Moore-style control FSM for a multicycle MIPS datapath
//             supporting lw, sw, R-type (add/sub/and/or/slt), beq and addi.
//             Unknown opcodes retire as NOPs after DECODE.
//  Ports    : clk, reset (async, active-low)
//             Op[5:0], Funct[5:0], zero   - instruction fields / ALU flag
//             IorD, MemWrite, IRWrite, PCSrc, RegWrite, PCEn, RegDst,
//             MemtoReg, ALUSrcA, ALUSrcB[1:0], ALUControl[2:0]
//                                         - datapath selects / enables
//             state_o[3:0]               - current state code (debug)
//             instr_count[31:0]          - retired instruction counter
//  Revision : 1.0 - initial release
// ============================================================================
module mips_multi_control
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        zero,
  output logic        IorD,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        PCEn,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [3:0]  state_o,
  output logic [31:0] instr_count
);

  state_t      r_state;
  state_t      w_next;
  logic        w_pc_write;
  logic        w_branch;
  logic        w_retire;
  logic [2:0]  w_funct_alu;
  logic        w_funct_ok;
  logic [31:0] r_instr_count;

  alu_decoder u_alu_decoder (
    .i_funct       (Funct),
    .o_alu_control (w_funct_alu),
    .o_supported   (w_funct_ok)
  );

  // State register: reset forces FETCH immediately, so a write-enable held
  // in the aborted state drops without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next     = S_FETCH;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCSrc      = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = C_SRCB_REG;
    ALUControl = C_ALU_ADD;
    w_pc_write = 1'b0;
    w_branch   = 1'b0;

    case (r_state)
      S_FETCH: begin
        IRWrite    = 1'b1;
        w_pc_write = 1'b1;
        ALUSrcB    = C_SRCB_FOUR;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        // ALU computes the branch target speculatively into ALUOut.
        ALUSrcB = C_SRCB_IMM_SH2;
        case (Op)
          C_OP_LW, C_OP_SW: w_next = S_MEMADR;
          C_OP_RTYPE:       w_next = S_RTEXEC;
          C_OP_BEQ:         w_next = S_BRANCH;
          C_OP_ADDI:        w_next = S_ADDIEXEC;
          default:          w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = C_SRCB_IMM;
        w_next  = (Op == C_OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_next   = S_FETCH;
      end
      S_RTEXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = w_funct_alu;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        // Unsupported funct still retires but must not corrupt the regfile.
        RegWrite = w_funct_ok;
        RegDst   = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = C_ALU_SUB;
        PCSrc      = 1'b1;
        w_branch   = 1'b1;
        w_next     = S_FETCH;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = C_SRCB_IMM;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // PCEn is the only Mealy term: the branch decision needs the live zero flag.
  assign PCEn = w_pc_write | (w_branch & zero);

  // An instruction retires on every entry into FETCH from another state.
  assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

  // The counter is rewritten every cycle (adding 0 when nothing retires) so
  // it always reflects its own current value plus the retire pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_count <= 32'd0;
    end else begin
      r_instr_count <= r_instr_count + {31'd0, w_retire};
    end
  end

  assign instr_count = r_instr_count;
  assign state_o     = r_state;

endmodule : mips_multi_control
`default_nettype wire

// File: tb/tb_mips_multi_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_multi_control
//  Purpose  : Self-checking bench for mips_multi_control. Directed cases for
//             lw, R-type sub, beq taken/not-taken, NOP opcode, reset abort
//             and counter wrap, followed by random instruction streams
//             checked against a per-instruction reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multi_control;

  logic        clk;
  logic        reset;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic        zero;
  logic        IorD, MemWrite, IRWrite, PCSrc, RegWrite, PCEn;
  logic        RegDst, MemtoReg, ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [3:0]  state_o;
  logic [31:0] instr_count;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_count;

  mips_multi_control dut (
    .clk         (clk),
    .reset       (reset),
    .Op          (Op),
    .Funct       (Funct),
    .zero        (zero),
    .IorD        (IorD),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .PCSrc       (PCSrc),
    .RegWrite    (RegWrite),
    .PCEn        (PCEn),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUControl  (ALUControl),
    .state_o     (state_o),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control bundle, same packing as ref_ctrl below.
  logic [13:0] obs_ctrl;
  assign obs_ctrl = {IorD, MemWrite, IRWrite, PCSrc, RegWrite, PCEn, RegDst,
                     MemtoReg, ALUSrcA, ALUSrcB, ALUControl};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic ref_funct_ok(input logic [5:0] f);
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2a);
  endfunction

  // Expected control outputs for a named step of an instruction.
  function automatic logic [13:0] ref_ctrl(input int st, input logic [5:0] f, input logic z);
    logic       iord, mw, irw, pcsrc, rw, pcen, rd, m2r, sa;
    logic [1:0] sb;
    logic [2:0] ac;
    iord = 0; mw = 0; irw = 0; pcsrc = 0; rw = 0; pcen = 0; rd = 0; m2r = 0; sa = 0;
    sb = 2'b00; ac = 3'b010;
    case (st)
      0:  begin irw = 1; pcen = 1; sb = 2'b01; end          // fetch
      1:  begin sb = 2'b11; end                               // decode
      2:  begin sa = 1; sb = 2'b10; end                       // mem address
      3:  begin iord = 1; end                                 // mem read
      4:  begin rw = 1; m2r = 1; end                          // mem writeback
      5:  begin mw = 1; iord = 1; end                         // mem write
      6:  begin sa = 1; ac = ref_alu(f); end                  // R execute
      7:  begin rd = 1; rw = ref_funct_ok(f); end             // ALU writeback
      8:  begin sa = 1; ac = 3'b110; pcsrc = 1; pcen = z; end // branch
      9:  begin sa = 1; sb = 2'b10; end                       // addi execute
      10: begin rw = 1; end                                   // addi writeback
      default: ;
    endcase
    return {iord, mw, irw, pcsrc, rw, pcen, rd, m2r, sa, sb, ac};
  endfunction

  // Called at a falling edge with the DUT in FETCH; walks one instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic zbr);
    int seq[$];
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b000100: seq = '{0, 1, 8};
      6'b001000: seq = '{0, 1, 9, 10};
      default:   seq = '{0, 1};
    endcase
    Op    = op;
    Funct = f;
    foreach (seq[i]) begin
      zero = (seq[i] == 8) ? zbr : 1'($urandom_range(1));
      #1;
      chk($sformatf("state op=%0h step%0d", op, i), 32'(state_o), 32'(seq[i]));
      chk($sformatf("ctrl op=%0h f=%0h st=%0d", op, f, seq[i]), 32'(obs_ctrl),
          32'(ref_ctrl(seq[i], f, zero)));
      @(negedge clk);
    end
    exp_count = exp_count + 1;
    #1;
    chk($sformatf("count after op=%0h", op), instr_count, exp_count);
    chk("back in fetch", 32'(state_o), 32'd0);
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] fns[6];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000000};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};

    reset = 1'b0; Op = '0; Funct = '0; zero = 1'b0;
    exp_count = 32'd0;
    @(negedge clk);
    #1;
    chk("reset state", 32'(state_o), 32'd0);
    chk("reset count", instr_count, 32'd0);
    chk("reset ctrl", 32'(obs_ctrl), 32'(ref_ctrl(0, 6'h00, 1'b0)));
    @(negedge clk);
    reset = 1'b1;

    // Directed: lw, R-type sub, beq taken and not taken, NOP opcode, addi, sw
    run_instr(6'b100011, 6'h00, 1'b0);
    run_instr(6'b000000, 6'h22, 1'b0);
    run_instr(6'b000100, 6'h00, 1'b1);
    run_instr(6'b000100, 6'h00, 1'b0);
    run_instr(6'b111111, 6'h00, 1'b0);
    run_instr(6'b000000, 6'h3f, 1'b0);
    run_instr(6'b001000, 6'h00, 1'b0);
    run_instr(6'b101011, 6'h00, 1'b0);

    // Reset asserted while MemWrite is active aborts the store at once.
    Op = 6'b101011; Funct = 6'h00; zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("sw reaches memwr", 32'(state_o), 32'd5);
    chk("memwrite before abort", 32'(MemWrite), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort memwrite", 32'(MemWrite), 32'd0);
    chk("abort state", 32'(state_o), 32'd0);
    chk("abort count", instr_count, 32'd0);
    exp_count = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    run_instr(6'b100011, 6'h00, 1'b0);

    // Counter wrap: hold at all-ones through a store, then let it retire.
    Op = 6'b101011;
    force dut.r_instr_count = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    chk("wrap at memwr state", 32'(state_o), 32'd5);
    chk("wrap preload", instr_count, 32'hFFFF_FFFF);
    release dut.r_instr_count;
    @(negedge clk);
    #1;
    chk("wrap to zero", instr_count, 32'd0);
    chk("wrap fetch", 32'(state_o), 32'd0);
    exp_count = 32'd0;

    // Random instruction stream
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      logic [5:0] f;
      int         k;
      k  = int'($urandom_range(6));
      op = (k == 6) ? 6'($urandom) : ops[k];
      f  = ($urandom_range(3) == 0) ? 6'($urandom) : fns[$urandom_range(5)];
      run_instr(op, f, 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule : tb_mips_multi_control
`default_nettype wire
